prbs5_checker: RTL
==================

Name: prbs5_checker

Overview:
- Serial receiver/checker for the 5-bit PRBS stream (x^5+x^3+1, period 31) that our LFSR generators emit one bit per clock.
- Self-synchronises to the incoming stream, declares lock, then counts bit errors and detects loss of lock.
- Sits on the sink side of a loopback/link test: the generator's serial output feeds din.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions in SEARCH needed to enter LOCKED.
- WIN, 32: length of the loss-of-lock window, in valid bits.
- ERR_LIMIT, 4: errors within one window that force a return to SEARCH.
- CNT_W, 16: width of err_cnt and bit_cnt.

Ports:
- sys_clk  in  1  single clock, all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- din  in  1  received serial PRBS bit.
- din_valid  in  1  din is sampled only when this is 1; otherwise all state holds.
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt; lock state is unaffected.
- locked  out  1  1 while in LOCKED.
- err  out  1  one-cycle pulse, the cycle after a mismatching bit is sampled in LOCKED.
- err_cnt  out  CNT_W  saturating count of mismatches seen while LOCKED.
- bit_cnt  out  CNT_W  saturating count of valid bits checked while LOCKED.

Behaviour:
- Reset values: history=0, fill=0, state=SEARCH, match cnt=0, window counters=0, locked=0, err=0, err_cnt=0, bit_cnt=0.
- Sequence rule: received bit o(n) must equal o(n-5) XOR o(n-3).
  - Seed 5'b00001 gives 1,0,0,1,0,1,1,0,0,1,...
- History: 5-bit shift register h, newest bit at h[0].
  - Predicted bit p = h[4] ^ h[2].
- SEARCH state:
  - Every valid bit shifts din into h.
  - Until 5 valid bits have been shifted in (fill counter), no comparison is made.
  - After that, each valid bit is compared with p. A match increments the match count; a mismatch clears it.
  - A match made while h==0 does not count (it would otherwise lock onto all-zeros), and the match count is cleared.
  - When the match count reaches LOCK_CNT, the state goes to LOCKED. locked rises the cycle after the LOCK_CNT-th match is sampled.
- LOCKED state:
  - Every valid bit shifts p, not din, into h, so one flipped bit counts as exactly one error.
  - bit_cnt increments on every valid bit.
  - On mismatch: err=1 next cycle, err_cnt increments, and the window error count increments.
  - Both counters saturate at all-ones.
- Loss of lock:
  - The window bit counter counts valid bits in LOCKED and is fixed, not sliding. At WIN bits it resets along with the window error count.
  - If the window error count reaches ERR_LIMIT, the state goes to SEARCH with match cnt=0 and fill=0.
  - locked falls the cycle after the ERR_LIMIT-th error. err still pulses for that bit.
- clr_cnt:
  - Zeroes err_cnt and bit_cnt. If a count event occurs in the same cycle, the clear wins.
  - Does not touch lock state or window counters.
- din_valid=0: no shift, no compare, no counting. err is 0.
- Asynchronous sys_rst mid-stream returns all state to reset values at once.
  - After release, relock requires 5 fill bits plus LOCK_CNT matches.

Decomposition:
- Shared package:
  - state enum {SEARCH, LOCKED}.
  - PRBS5 tap constants (taps 5 and 3) and the reference seed 5'b00001, shared with the generator blocks.
- One natural sub-module: prbs5_predictor (history register plus p, with a shift-source select). Counters and FSM stay in the top.

Test Plan:
- Clean lock: generator seeded 00001 drives din, din_valid=1 continuously from cycle 0 -> locked=1 from cycle 13; err never pulses; after 100 bits in LOCKED bit_cnt=100, err_cnt=0.
- Single error: after lock, invert one bit -> exactly one err pulse on the following cycle, err_cnt=1, locked stays 1, no further errors.
- Loss of lock: after lock, invert 4 bits within one 32-bit window -> 4 err pulses, locked=0 after the 4th; clean stream then relocks after 5+8 valid bits.
- All-zero input: din=0, din_valid=1 for 200 cycles -> locked stays 0, err_cnt=0.
- Gapped valid: din_valid toggling 1/0 with the same PRBS bits -> lock after 13 valid bits (cycle 25); counters advance only on valid cycles.
- Reset/clear: sys_rst pulse while locked -> locked, counters=0 immediately; clr_cnt with err_cnt=3 coincident with an error -> err_cnt=0.

Source files
------------

// File: rtl/prbs5_checker_pkg.sv
// rtl/prbs5_checker_pkg.sv - shared PRBS5 (x^5+x^3+1) types and constants
package prbs5_checker_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int         PRBS5_TAP_A = 5;
  localparam int         PRBS5_TAP_B = 3;
  localparam logic [4:0] PRBS5_SEED  = 5'b00001;
  localparam int         FILL_BITS   = 5;

  // History holds the newest bit at [0], so tap k sits at index k-1.
  function automatic logic prbs5_predict(input logic [4:0] hist);
    return hist[PRBS5_TAP_A-1] ^ hist[PRBS5_TAP_B-1];
  endfunction

endpackage

// File: rtl/prbs5_predictor.sv
// rtl/prbs5_predictor.sv - PRBS5 history register and next-bit prediction
module prbs5_predictor
  import prbs5_checker_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       shift_i,
  input  logic       sel_pred_i,
  input  logic       din_i,
  output logic [4:0] hist_o,
  output logic       pred_o
);

  logic [4:0] hist_q, hist_d;

  assign hist_o = hist_q;
  assign pred_o = prbs5_predict(hist_q);

  // Once locked the predictor free-runs on its own output so a flipped bit is seen once.
  always_comb begin
    hist_d = hist_q;
    if (shift_i) begin
      hist_d = {hist_q[3:0], (sel_pred_i ? pred_o : din_i)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/prbs5_checker.sv
// rtl/prbs5_checker.sv - self-synchronising PRBS5 serial checker with error counting
module prbs5_checker
  import prbs5_checker_pkg::*;
#(
  parameter int LOCK_CNT  = 8,
  parameter int WIN       = 32,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int FW  = 3;
  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int WBW = $clog2(WIN);
  localparam int EW  = $clog2(ERR_LIMIT + 1);

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WBW-1:0]   win_bit_q, win_bit_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic       shift, sel_pred, pred, mismatch, win_end;
  logic [4:0] hist;

  prbs5_predictor u_pred (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .shift_i    (shift),
    .sel_pred_i (sel_pred),
    .din_i      (din),
    .hist_o     (hist),
    .pred_o     (pred)
  );

  assign mismatch = din ^ pred;
  assign win_end  = (win_bit_q == WBW'(WIN - 1));

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_bit_d = win_bit_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift     = 1'b0;
    sel_pred  = 1'b0;
    if (din_valid) begin
      shift = 1'b1;
      unique case (state_q)
        SEARCH: begin
          if (fill_q != FW'(FILL_BITS)) begin
            fill_d = fill_q + 1'b1;
          end else if (!mismatch && (hist != '0)) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d   = LOCKED;
              match_d   = '0;
              win_bit_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          sel_pred = 1'b1;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
          if (win_end) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + 1'b1;
          end
          if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            // An error on the window's last bit still counts toward that window.
            if (win_err_q == EW'(ERR_LIMIT - 1)) begin
              state_d   = SEARCH;
              fill_d    = '0;
              match_d   = '0;
              win_bit_d = '0;
              win_err_d = '0;
            end else if (!win_end) begin
              win_err_d = win_err_q + 1'b1;
            end
          end
        end
      endcase
    end
    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= SEARCH;
      fill_q    <= '0;
      match_q   <= '0;
      win_bit_q <= '0;
      win_err_q <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_bit_q <= win_bit_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked  = (state_q == LOCKED);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule
